// File: rtl/ysyx_exu_rsv_pkg.sv
// Shared types and constants for the ALU/branch reservation station.
package ysyx_rs_pkg;

  localparam int RS_TAG_W  = 4;
  // A source tag of zero means the operand value is already present.
  localparam int TAG_READY = 0;

  typedef logic [RS_TAG_W-1:0] rs_tag_t;

  // Operand-independent part of a queued micro-op.
  typedef struct packed {
    logic [4:0]  alu_op;
    logic        jen;
    logic        ben;
    logic [31:0] imm;
    logic [31:0] pc;
  } rs_entry_t;

endpackage

// File: rtl/ysyx_exu_rsv_if.sv
// Dispatch, CDB snoop and issue bundle of the reservation station.
// master: dispatcher / CDB / execute side; slave: the reservation station.
interface ysyx_exu_rsv_if
  import ysyx_rs_pkg::*;
#(
  parameter int RS_SIZE = 4,
  parameter int TAG_W   = 4,
  parameter int XLEN    = 32
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic             flush;

  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_alu_op;
  logic             in_jen;
  logic             in_ben;
  logic [XLEN-1:0]  in_op1;
  logic [XLEN-1:0]  in_op2;
  logic [TAG_W-1:0] in_qj;
  logic [TAG_W-1:0] in_qk;
  logic [TAG_W-1:0] in_dest;
  logic [31:0]      in_imm;
  logic [31:0]      in_pc;
  logic [IDX_W-1:0] out_rs_idx;

  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_dest;
  logic [XLEN-1:0]  cdb_result;

  logic             iss_valid;
  logic             iss_ready;
  logic [4:0]       iss_alu_op;
  logic             iss_jen;
  logic             iss_ben;
  logic [XLEN-1:0]  iss_op1;
  logic [XLEN-1:0]  iss_op2;
  logic [31:0]      iss_imm;
  logic [31:0]      iss_pc;
  logic [TAG_W-1:0] iss_dest;

  modport master (
    output flush,
    output in_valid, in_alu_op, in_jen, in_ben, in_op1, in_op2,
    output in_qj, in_qk, in_dest, in_imm, in_pc,
    input  in_ready, out_rs_idx,
    output cdb_valid, cdb_dest, cdb_result,
    output iss_ready,
    input  iss_valid, iss_alu_op, iss_jen, iss_ben, iss_op1, iss_op2,
    input  iss_imm, iss_pc, iss_dest
  );

  modport slave (
    input  flush,
    input  in_valid, in_alu_op, in_jen, in_ben, in_op1, in_op2,
    input  in_qj, in_qk, in_dest, in_imm, in_pc,
    output in_ready, out_rs_idx,
    input  cdb_valid, cdb_dest, cdb_result,
    input  iss_ready,
    output iss_valid, iss_alu_op, iss_jen, iss_ben, iss_op1, iss_op2,
    output iss_imm, iss_pc, iss_dest
  );

endinterface

// File: rtl/ysyx_rs_age_sel.sv
// Age matrix for the reservation station: tracks relative dispatch order and
// picks the oldest entry among those that are ready.
module ysyx_rs_age_sel
  import ysyx_rs_pkg::*;
#(
  parameter int RS_SIZE = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [RS_SIZE-1:0] alloc_oh,
  input  logic [RS_SIZE-1:0] free_oh,
  input  logic [RS_SIZE-1:0] ready,
  output logic [RS_SIZE-1:0] oldest
);

  // older[r][c] set: entry r was dispatched before entry c.
  logic [RS_SIZE-1:0] older [RS_SIZE];
  logic [RS_SIZE-1:0] blocked;

  // A newcomer is younger than everything; its own row and freed rows claim no seniority.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < RS_SIZE; r++) older[r] <= '0;
    end else begin
      for (int r = 0; r < RS_SIZE; r++) begin
        for (int c = 0; c < RS_SIZE; c++) begin
          if (alloc_oh[c] && r != c)
            older[r][c] <= 1'b1;
          else if (alloc_oh[r] || free_oh[r])
            older[r][c] <= 1'b0;
        end
      end
    end
  end

  // An entry wins when no other ready entry is older than it.
  always_comb begin
    blocked = '0;
    for (int c = 0; c < RS_SIZE; c++)
      for (int r = 0; r < RS_SIZE; r++)
        if (r != c && ready[r] && older[r][c]) blocked[c] = 1'b1;
    oldest = ready & ~blocked;
  end

endmodule

// File: rtl/ysyx_exu_rsv.sv
// Reservation station feeding the ALU/branch execute unit. Holds dispatched
// micro-ops, captures missing operands from the CDB and issues the oldest
// ready entry.
// Optional feature macro: YSYX_RS_CDB_BYPASS_EN -- when defined, a dispatch
// whose source tag matches the same-cycle CDB broadcast captures the value
// directly; otherwise dispatch is held off for that cycle.
module ysyx_exu_rsv
  import ysyx_rs_pkg::*;
#(
  parameter int RS_SIZE = 4,
  parameter int TAG_W   = 4,
  parameter int XLEN    = 32
) (
  input  logic          clock,
  input  logic          reset,
  ysyx_exu_rsv_if.slave bus
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam logic [TAG_W-1:0] TAG_RDY = TAG_W'(TAG_READY);

  logic [RS_SIZE-1:0] busy;
  rs_entry_t          pl   [RS_SIZE];
  logic [TAG_W-1:0]   qj   [RS_SIZE];
  logic [TAG_W-1:0]   qk   [RS_SIZE];
  logic [TAG_W-1:0]   dest [RS_SIZE];
  logic [XLEN-1:0]    vj   [RS_SIZE];
  logic [XLEN-1:0]    vk   [RS_SIZE];

  logic               free_any;
  logic [IDX_W-1:0]   alloc_idx;
  logic               hit_j;
  logic               hit_k;
  logic               dispatch;
  logic               issue;
  logic [RS_SIZE-1:0] ready;
  logic [RS_SIZE-1:0] oldest;
  logic [RS_SIZE-1:0] alloc_oh;
  logic [RS_SIZE-1:0] free_oh;
  logic [IDX_W-1:0]   iss_idx;

  // Lowest-index free entry, taken from registered busy bits only.
  always_comb begin
    free_any  = 1'b0;
    alloc_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_any  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
    end
  end

  // Dispatching operand whose producer is broadcasting right now.
  assign hit_j = bus.cdb_valid && (bus.in_qj != TAG_RDY) && (bus.in_qj == bus.cdb_dest);
  assign hit_k = bus.cdb_valid && (bus.in_qk != TAG_RDY) && (bus.in_qk == bus.cdb_dest);

`ifdef YSYX_RS_CDB_BYPASS_EN
  assign bus.in_ready = free_any;
`else
  // The entry would miss this broadcast, so the dispatcher retries next cycle.
  assign bus.in_ready = free_any && !(hit_j || hit_k);
`endif

  assign bus.out_rs_idx = alloc_idx;
  assign dispatch       = bus.in_valid && bus.in_ready;

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++)
      ready[i] = busy[i] && (qj[i] == TAG_RDY) && (qk[i] == TAG_RDY);
  end

  assign alloc_oh = dispatch ? (RS_SIZE'(1) << alloc_idx) : '0;
  assign free_oh  = issue ? oldest : '0;

  ysyx_rs_age_sel #(.RS_SIZE(RS_SIZE)) u_age (
    .clock    (clock),
    .reset    (reset || bus.flush),
    .alloc_oh (alloc_oh),
    .free_oh  (free_oh),
    .ready    (ready),
    .oldest   (oldest)
  );

  // Encode the one-hot winner; defaults to entry 0 when nothing is ready.
  always_comb begin
    iss_idx = '0;
    for (int i = 0; i < RS_SIZE; i++)
      if (oldest[i]) iss_idx = IDX_W'(i);
  end

  assign bus.iss_valid  = |ready;
  assign issue          = bus.iss_valid && bus.iss_ready;
  assign bus.iss_alu_op = pl[iss_idx].alu_op;
  assign bus.iss_jen    = pl[iss_idx].jen;
  assign bus.iss_ben    = pl[iss_idx].ben;
  assign bus.iss_imm    = pl[iss_idx].imm;
  assign bus.iss_pc     = pl[iss_idx].pc;
  assign bus.iss_op1    = vj[iss_idx];
  assign bus.iss_op2    = vk[iss_idx];
  assign bus.iss_dest   = dest[iss_idx];

  // Entry state: flush/reset wipe everything, else dispatch, issue and wakeup.
  always_ff @(posedge clock) begin
    if (reset || bus.flush) begin
      busy <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        pl[i]   <= '0;
        qj[i]   <= '0;
        qk[i]   <= '0;
        dest[i] <= '0;
        vj[i]   <= '0;
        vk[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (dispatch && alloc_idx == IDX_W'(i)) begin
          busy[i] <= 1'b1;
          pl[i]   <= '{alu_op: bus.in_alu_op, jen: bus.in_jen, ben: bus.in_ben,
                       imm: bus.in_imm, pc: bus.in_pc};
          dest[i] <= bus.in_dest;
          qj[i]   <= bus.in_qj;
          vj[i]   <= bus.in_op1;
          qk[i]   <= bus.in_qk;
          vk[i]   <= bus.in_op2;
`ifdef YSYX_RS_CDB_BYPASS_EN
          if (hit_j) begin
            qj[i] <= TAG_RDY;
            vj[i] <= bus.cdb_result;
          end
          if (hit_k) begin
            qk[i] <= TAG_RDY;
            vk[i] <= bus.cdb_result;
          end
`endif
        end else if (busy[i]) begin
          if (issue && oldest[i]) busy[i] <= 1'b0;
          if (bus.cdb_valid && qj[i] != TAG_RDY && qj[i] == bus.cdb_dest) begin
            qj[i] <= TAG_RDY;
            vj[i] <= bus.cdb_result;
          end
          if (bus.cdb_valid && qk[i] != TAG_RDY && qk[i] == bus.cdb_dest) begin
            qk[i] <= TAG_RDY;
            vk[i] <= bus.cdb_result;
          end
        end
      end
    end
  end

endmodule
